// File: rtl/toggle_stream_receiver.sv
// Toggle-encoded serial receiver: start bit, 8 data bits LSB-first, stop bit, with a one-word output holding register.
// Optional even-parity bit between data and stop when TOGGLE_RX_PARITY_EN is defined.
module toggle_stream_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_in,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

`ifdef TOGGLE_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t      state, state_nxt;
  logic        line_prev;
  logic        b;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic        shift_en;
  logic        word_done;
  logic        stop_bad;
  logic        word_ok;
  logic        par_fail;

  assign b = line_in ^ line_prev;

`ifdef TOGGLE_RX_PARITY_EN
  logic par_load;
  logic par_bad;

  // Parity verdict is latched in PARITY and applied when the stop bit arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_load) par_bad <= (^shift_reg) ^ b;
      parity_err <= par_fail;
    end
  end

  assign par_fail = word_done & par_bad;
  assign word_ok  = word_done & ~par_bad;
`else
  assign par_fail   = 1'b0;
  assign word_ok    = word_done;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    word_done = 1'b0;
    stop_bad  = 1'b0;
`ifdef TOGGLE_RX_PARITY_EN
    par_load  = 1'b0;
`endif
    case (state)
      IDLE: if (b) state_nxt = DATA;
      DATA: begin
        shift_en = 1'b1;
`ifdef TOGGLE_RX_PARITY_EN
        if (bit_cnt == 3'd7) state_nxt = PARITY;
`else
        if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
      end
`ifdef TOGGLE_RX_PARITY_EN
      PARITY: begin
        par_load  = 1'b1;
        state_nxt = STOP;
      end
`endif
      STOP: begin
        // A bad stop bit returns to IDLE and is never reused as a start bit.
        state_nxt = IDLE;
        if (b) stop_bad  = 1'b1;
        else   word_done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_prev  <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      line_prev <= line_in;
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (shift_en) begin
        shift_reg <= {b, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end else if (state == IDLE) begin
        bit_cnt <= '0;
      end
      // Accepting the held word in the completion cycle frees the slot for the new one.
      if (word_ok) begin
        if (!data_valid || out_ready) begin
          data_out   <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && out_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
